fetch_prefetch_unit: RTL and testbench

- Parametrised, decoupled instruction-fetch front end for the RISC-V core; the next generation of the fixed single-cycle fetch path.
- Issues in-order, pipelined requests to instruction memory over a valid/ready request channel and an in-order response channel.
- Buffers returned instructions with their PCs in a prefetch FIFO and hands them to decode over a valid/ready handshake.
- Branch/jump redirects flush all buffered and in-flight instructions.

---
 rtl/riscv_pkg.sv | 10 +
 rtl/sync_fifo.sv | 60 ++++++
 rtl/fetch_prefetch_unit.sv | 114 +++++++++++
 tb/tb_fetch_prefetch_unit.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared constants for the RISC-V front end: widths, reset PC, canonical NOP and PC stride.
package riscv_pkg;

  localparam int          XLEN_DEF     = 64;
  localparam int          INSTR_W      = 32;
  localparam logic [63:0] RESET_PC_DEF = 64'h0;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
  localparam int          PC_STEP      = 4;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with flush and occupancy count; DEPTH need not be a power of two.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_do_pop  = i_pop && !o_empty && !i_flush;
  assign w_do_push = i_push && (!o_full || w_do_pop) && !i_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Decoupled instruction fetch: pipelined imem requests, in-order responses into a prefetch
// buffer, valid/ready hand-off to decode, and redirect flush with stale-response dropping.
module fetch_prefetch_unit
  import riscv_pkg::*;
#(
  parameter int              XLEN            = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC        = XLEN'(RESET_PC_DEF),
  parameter int              FIFO_DEPTH      = 4,
  parameter int              MAX_OUTSTANDING = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  output logic                        imem_req_valid,
  input  logic                        imem_req_ready,
  output logic [XLEN-1:0]             imem_req_addr,
  input  logic                        imem_rsp_valid,
  input  logic [INSTR_W-1:0]          imem_rsp_data,
  input  logic                        redirect_valid,
  input  logic [XLEN-1:0]             redirect_pc,
  output logic                        id_valid,
  input  logic                        id_ready,
  output logic [INSTR_W-1:0]          id_instr,
  output logic [XLEN-1:0]             id_pc,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int OUT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam int SUM_W   = ((CNT_W > OUT_W) ? CNT_W : OUT_W) + 1;
  localparam int ENTRY_W = XLEN + INSTR_W;

  logic [XLEN-1:0]              r_fetch_pc;
  logic [OUT_W-1:0]             r_outstanding;
  logic [OUT_W-1:0]             r_drop_cnt;
  logic                         w_req_fire;
  logic                         w_rsp_fire;
  logic                         w_pf_push;
  logic                         w_pf_pop;
  logic                         w_pf_empty;
  logic                         w_pf_full;
  logic                         w_if_empty;
  logic                         w_if_full;
  logic [$clog2(MAX_OUTSTANDING):0] w_if_count;
  logic [XLEN-1:0]              w_rsp_pc;
  logic [ENTRY_W-1:0]           w_pf_head;
  logic [SUM_W-1:0]             w_credit_used;

  // Buffer slots are reserved at request time, so every in-flight response has a home.
  assign w_credit_used  = SUM_W'(r_outstanding) + SUM_W'(fifo_count);
  assign imem_req_valid = rst_n && !redirect_valid
                          && (r_outstanding < OUT_W'(MAX_OUTSTANDING))
                          && (w_credit_used < SUM_W'(FIFO_DEPTH));
  assign imem_req_addr  = r_fetch_pc;
  assign w_req_fire     = imem_req_valid && imem_req_ready;

  assign w_rsp_fire = imem_rsp_valid && (r_outstanding != '0);
  assign w_pf_push  = w_rsp_fire && (r_drop_cnt == '0) && !redirect_valid;

  assign id_valid = !w_pf_empty && !redirect_valid;
  assign w_pf_pop = id_valid && id_ready;
  assign id_pc    = w_pf_empty ? '0 : w_pf_head[ENTRY_W-1:INSTR_W];
  assign id_instr = w_pf_empty ? '0 : w_pf_head[INSTR_W-1:0];

  // Every response still expected at redirect time belongs to the old path and must be dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc    <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else begin
      if (redirect_valid)  r_fetch_pc <= redirect_pc & ~XLEN'(3);
      else if (w_req_fire) r_fetch_pc <= r_fetch_pc + XLEN'(PC_STEP);
      r_outstanding <= r_outstanding + OUT_W'(w_req_fire) - OUT_W'(w_rsp_fire);
      if (redirect_valid)
        r_drop_cnt <= r_outstanding - OUT_W'(w_rsp_fire);
      else if (w_rsp_fire && (r_drop_cnt != '0))
        r_drop_cnt <= r_drop_cnt - OUT_W'(1);
    end
  end

  sync_fifo #(.WIDTH(XLEN), .DEPTH(MAX_OUTSTANDING)) u_inflight_q (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_req_fire),
    .i_data  (r_fetch_pc),
    .i_pop   (w_rsp_fire),
    .i_flush (1'b0),
    .o_data  (w_rsp_pc),
    .o_empty (w_if_empty),
    .o_full  (w_if_full),
    .o_count (w_if_count)
  );

  sync_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_prefetch_q (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_pf_push),
    .i_data  ({w_rsp_pc, imem_rsp_data}),
    .i_pop   (w_pf_pop),
    .i_flush (redirect_valid),
    .o_data  (w_pf_head),
    .o_empty (w_pf_empty),
    .o_full  (w_pf_full),
    .o_count (fifo_count)
  );

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(w_pf_push && w_pf_full));
  a_inflight_sync: assert property (@(posedge clk) disable iff (!rst_n)
                                    int'(w_if_count) == int'(r_outstanding));
  a_inflight_empty: assert property (@(posedge clk) disable iff (!rst_n)
                                     w_if_empty == (r_outstanding == '0));
  a_inflight_room: assert property (@(posedge clk) disable iff (!rst_n) !(w_req_fire && w_if_full && !w_rsp_fire));

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Bench for fetch_prefetch_unit: phase table plus redirect/reset sequences, with an in-order
// memory model and a scoreboard of instructions decode should receive.
module tb_fetch_prefetch_unit;

  localparam int          XLEN            = 64;
  localparam logic [63:0] RESET_PC        = 64'h0;
  localparam int          FIFO_DEPTH      = 4;
  localparam int          MAX_OUTSTANDING = 2;

  logic                        clk = 1'b0;
  logic                        rst_n = 1'b0;
  logic                        imem_req_valid;
  logic                        imem_req_ready = 1'b0;
  logic [XLEN-1:0]             imem_req_addr;
  logic                        imem_rsp_valid = 1'b0;
  logic [31:0]                 imem_rsp_data = '0;
  logic                        redirect_valid = 1'b0;
  logic [XLEN-1:0]             redirect_pc = '0;
  logic                        id_valid;
  logic                        id_ready = 1'b0;
  logic [31:0]                 id_instr;
  logic [XLEN-1:0]             id_pc;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  always #5 clk = ~clk;

  fetch_prefetch_unit #(
    .XLEN(XLEN), .RESET_PC(RESET_PC), .FIFO_DEPTH(FIFO_DEPTH), .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc),
    .fifo_count(fifo_count)
  );

  typedef struct { logic [63:0] addr; int due; int epoch; } memReq_t;
  typedef struct { logic [63:0] pc; logic [31:0] instr; } expEntry_t;
  typedef struct { int cycles; bit reqReady; bit idReady; int lat; bit checkEnd; int expCount; bit expReqValid; } phase_t;

  memReq_t     memQ[$];
  expEntry_t   sbQ[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          lat = 1;
  int          epoch = 0;
  bit          kReqReady = 0, kIdReady = 0;
  bit          redirectReq = 0, redirectOnRsp = 0, redirectFired = 0;
  logic [63:0] redirectTarget = '0;
  logic [63:0] expPc = '0;
  bit          sAcc = 0;
  logic [63:0] sAccAddr = '0;
  bit          pendPush = 0;
  expEntry_t   pendEntry;
  bit          prevStall = 0;
  logic [63:0] prevAddr = '0;
  bit          watchAcc = 0, watchId = 0;
  logic [63:0] watchAccAddr = '0, watchIdPc = '0;

  function automatic logic [31:0] instrOf(input logic [63:0] a);
    return a[31:0] ^ 32'hC0DE_0013;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Mid-cycle comparison of DUT outputs against the memory model and scoreboard.
  task automatic checkOutput();
    int outNow;
    bit expReq;
    sAcc = 0;
    if (!rst_n) begin
      check("req_valid in reset", 64'(imem_req_valid), 64'(0));
      check("id_valid in reset", 64'(id_valid), 64'(0));
      prevStall = 0;
      return;
    end
    outNow = memQ.size() + (imem_rsp_valid ? 1 : 0);
    expReq = !redirect_valid && (outNow < MAX_OUTSTANDING) && ((outNow + sbQ.size()) < FIFO_DEPTH);
    check("req_valid", 64'(imem_req_valid), 64'(expReq));
    if (!redirect_valid) check("fifo_count", 64'(fifo_count), 64'(sbQ.size()));
    check("id_valid", 64'(id_valid), 64'((sbQ.size() > 0) && !redirect_valid));
    if (id_valid && id_ready && sbQ.size() > 0) begin
      check("id_pc", id_pc, sbQ[0].pc);
      check("id_instr", 64'(id_instr), 64'(sbQ[0].instr));
      if (watchId) begin
        check("first id_pc", id_pc, watchIdPc);
        watchId = 0;
      end
      void'(sbQ.pop_front());
    end
    if (prevStall && !redirect_valid) begin
      check("held req_valid", 64'(imem_req_valid), 64'(1));
      check("held req_addr", imem_req_addr, prevAddr);
    end
    prevStall = imem_req_valid && !imem_req_ready;
    prevAddr  = imem_req_addr;
    if (imem_req_valid && imem_req_ready) begin
      sAcc = 1;
      sAccAddr = imem_req_addr;
      check("req_addr", imem_req_addr, expPc);
      if (watchAcc) begin
        check("first req_addr", imem_req_addr, watchAccAddr);
        watchAcc = 0;
      end
    end
  endtask

  // One clock: check this cycle, then advance memory model and drive next-cycle inputs.
  task automatic applyStimulus();
    memReq_t m;
    bit deliver;
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    #1;
    cyc++;
    if (sAcc) begin
      m.addr = sAccAddr; m.due = cyc - 1 + lat; m.epoch = epoch;
      memQ.push_back(m);
      expPc += 64'd4;
    end
    if (pendPush) begin
      sbQ.push_back(pendEntry);
      pendPush = 0;
    end
    deliver = rst_n && (memQ.size() > 0) && (memQ[0].due <= cyc);
    if (redirectReq || (redirectOnRsp && deliver)) begin
      if (redirectOnRsp && deliver) begin
        redirectOnRsp = 0;
        redirectFired = 1;
      end
      redirectReq = 0;
      redirect_valid = 1;
      redirect_pc = redirectTarget;
      epoch++;
      sbQ.delete();
      expPc = redirectTarget & ~64'h3;
    end else begin
      redirect_valid = 0;
    end
    imem_rsp_valid = 0;
    imem_rsp_data = '0;
    if (deliver) begin
      m = memQ.pop_front();
      imem_rsp_valid = 1;
      imem_rsp_data = instrOf(m.addr);
      if (m.epoch == epoch) begin
        pendPush = 1;
        pendEntry.pc = m.addr;
        pendEntry.instr = instrOf(m.addr);
      end
    end
    imem_req_ready = kReqReady;
    id_ready = kIdReady;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    phase_t phases[5];
    phases[0] = '{12, 1'b1, 1'b1, 1, 1'b1, 1, 1'b1};
    phases[1] = '{8,  1'b1, 1'b0, 1, 1'b1, 4, 1'b0};
    phases[2] = '{10, 1'b1, 1'b1, 1, 1'b1, 2, 1'b1};
    phases[3] = '{3,  1'b0, 1'b1, 1, 1'b1, 1, 1'b1};
    phases[4] = '{12, 1'b1, 1'b1, 3, 1'b0, 0, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    check("reset id_valid", 64'(id_valid), 64'(0));
    check("reset id_instr", 64'(id_instr), 64'(0));
    check("reset id_pc", id_pc, 64'(0));
    check("reset fifo_count", 64'(fifo_count), 64'(0));
    check("reset req_valid", 64'(imem_req_valid), 64'(0));

    expPc = RESET_PC;
    kReqReady = 1; kIdReady = 1;
    imem_req_ready = 1; id_ready = 1;
    watchAcc = 1; watchAccAddr = RESET_PC;
    rst_n = 1;

    for (int p = 0; p < 5; p++) begin
      kReqReady = phases[p].reqReady;
      kIdReady  = phases[p].idReady;
      lat       = phases[p].lat;
      repeat (phases[p].cycles) applyStimulus();
      #1;
      if (phases[p].checkEnd) begin
        check($sformatf("phase%0d fifo_count", p), 64'(fifo_count), 64'(phases[p].expCount));
        check($sformatf("phase%0d req_valid", p), 64'(imem_req_valid), 64'(phases[p].expReqValid));
      end
    end
    check("startup first request seen", 64'(watchAcc), 64'(0));

    // Redirect with responses in flight and instructions buffered.
    kIdReady = 0; kReqReady = 1; lat = 3;
    for (int i = 0; i < 40 && !(fifo_count >= 2 && memQ.size() >= 1); i++) applyStimulus();
    check("seqA setup reached", 64'(fifo_count >= 2 && memQ.size() >= 1), 64'(1));
    redirectReq = 1; redirectTarget = 64'h1002; kIdReady = 1; lat = 1;
    applyStimulus();
    watchAcc = 1; watchAccAddr = 64'h1000;
    watchId = 1; watchIdPc = 64'h1000;
    applyStimulus();
    #1;
    check("seqA flushed fifo_count", 64'(fifo_count), 64'(0));
    repeat (15) applyStimulus();
    check("seqA watchers fired", 64'({watchAcc, watchId}), 64'(0));

    // Redirect coinciding with a response, then a second redirect two cycles later.
    kIdReady = 1; lat = 2;
    redirectFired = 0; redirectOnRsp = 1; redirectTarget = 64'h2000;
    for (int i = 0; i < 20 && !redirectFired; i++) applyStimulus();
    check("seqB first redirect fired", 64'(redirectFired), 64'(1));
    applyStimulus();
    redirectReq = 1; redirectTarget = 64'h3000;
    applyStimulus();
    watchId = 1; watchIdPc = 64'h3000;
    repeat (20) applyStimulus();
    check("seqB drop_cnt drained", 64'(dut.r_drop_cnt), 64'(0));
    check("seqB second target reached decode", 64'(watchId), 64'(0));

    // Asynchronous reset with the buffer non-empty.
    kIdReady = 0;
    for (int i = 0; i < 20 && fifo_count == 0; i++) applyStimulus();
    check("seqC buffer non-empty", 64'(fifo_count != 0), 64'(1));
    rst_n = 0;
    #1;
    check("seqC id_valid", 64'(id_valid), 64'(0));
    check("seqC fifo_count", 64'(fifo_count), 64'(0));
    check("seqC req_valid", 64'(imem_req_valid), 64'(0));
    check("seqC id_pc", id_pc, 64'(0));
    memQ.delete(); sbQ.delete();
    pendPush = 0; prevStall = 0;
    imem_rsp_valid = 0; redirect_valid = 0;
    expPc = RESET_PC;
    watchAcc = 1; watchAccAddr = RESET_PC;
    repeat (2) applyStimulus();
    kIdReady = 1; id_ready = 1; lat = 1;
    rst_n = 1;
    repeat (10) applyStimulus();
    check("seqC first request after reset", 64'(watchAcc), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
